// File: rtl/channel_dispatcher.sv
// Steers one {PC,CC_ID} entry per cycle to the lowest-latency channel and holds it until accepted.
// Optional DISPATCHER_STATS_EN adds saturating per-channel dispatch and stall counters.
module channel_dispatcher #(
    parameter int PC_WIDTH            = 8,
    parameter int CC_ID               = 2,
    parameter int NUM_CH              = 4,
    parameter int LATENCY_COUNT_WIDTH = 10
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [PC_WIDTH+CC_ID-1:0]             in_data,
    input  logic [NUM_CH*LATENCY_COUNT_WIDTH-1:0] ch_latency,
    input  logic [NUM_CH-1:0]                     ch_ready,
    output logic [NUM_CH-1:0]                     ch_valid,
    output logic [PC_WIDTH+CC_ID-1:0]             ch_data,
`ifdef DISPATCHER_STATS_EN
    output logic [NUM_CH*16-1:0]                  dispatch_cnt,
    output logic [15:0]                           stall_cnt,
`endif
    output logic                                  busy
);

    localparam int W    = PC_WIDTH + CC_ID;
    localparam int L    = LATENCY_COUNT_WIDTH;
    localparam int CH_W = $clog2(NUM_CH);

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t            state_q;
    logic [W-1:0]      data_q;
    logic [CH_W-1:0]   tgt_q, tgt_d;
    logic [CH_W-1:0]   rr_q, rr_d;
    logic [NUM_CH-1:0] ch_valid_q, ch_valid_d;
    logic [L-1:0]      min_lat;
    logic              accept, dispatch;

    // Lowest latency wins; ties go to the first matching index at or after rr_q.
    always_comb begin
        int   idx;
        logic found;
        min_lat = ch_latency[L-1:0];
        for (int i = 1; i < NUM_CH; i++) begin
            if (ch_latency[i*L +: L] < min_lat) min_lat = ch_latency[i*L +: L];
        end
        tgt_d = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!found && ch_latency[idx*L +: L] == min_lat) begin
                tgt_d = CH_W'(idx);
                found = 1'b1;
            end
        end
        rr_d       = (tgt_d == CH_W'(NUM_CH-1)) ? '0 : tgt_d + 1'b1;
        ch_valid_d = '0;
        ch_valid_d[tgt_d] = 1'b1;
    end

    // Refill is allowed in the same cycle the held entry leaves.
    assign in_ready = (state_q == IDLE) || ch_ready[tgt_q];
    assign accept   = in_valid && in_ready;
    assign dispatch = (state_q == HOLD) && ch_ready[tgt_q];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            data_q     <= '0;
            tgt_q      <= '0;
            rr_q       <= '0;
            ch_valid_q <= '0;
        end else if (accept) begin
            state_q    <= HOLD;
            data_q     <= in_data;
            tgt_q      <= tgt_d;
            rr_q       <= rr_d;
            ch_valid_q <= ch_valid_d;
        end else if (dispatch) begin
            state_q    <= IDLE;
            ch_valid_q <= '0;
        end
    end

    assign ch_valid = ch_valid_q;
    assign ch_data  = data_q;
    assign busy     = (state_q == HOLD);

`ifdef DISPATCHER_STATS_EN
    logic [NUM_CH-1:0][15:0] dcnt_q;
    logic [15:0]             scnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dcnt_q <= '0;
            scnt_q <= '0;
        end else begin
            if (dispatch && dcnt_q[tgt_q] != 16'hFFFF) dcnt_q[tgt_q] <= dcnt_q[tgt_q] + 16'd1;
            if (state_q == HOLD && !ch_ready[tgt_q] && scnt_q != 16'hFFFF) scnt_q <= scnt_q + 16'd1;
        end
    end

    assign dispatch_cnt = dcnt_q;
    assign stall_cnt    = scnt_q;
`endif

endmodule
